arm_dmem_arbiter: RTL and testbench
===================================

# arm_dmem_arbiter

Arbiter that shares the single-port data memory between the single-cycle CPU and one external requester (DMA or program loader). It sits between the CPU data port and the data memory inside the SoC. The CPU is favoured by default and sees a purely combinational path. A starvation counter forces an external grant after a bounded wait, and stalls the CPU for that cycle.

## Interface

Parameters:

- `BusWidth`, 32, address and data width.
- `MaxWait`, 4, consecutive refused cycles before the external requester is force-granted; legal range is 1..255.

Ports:

- `i_CLK`  in  1  clock.
- `i_RESET`  in  1  reset, synchronous and active-high.
- `i_CPU_Req`  in  1  CPU performs a load/store this cycle.
- `i_CPU_Write`  in  1  CPU store.
- `i_CPU_Address`  in  BusWidth  CPU byte address.
- `i_CPU_Write_Data`  in  BusWidth  CPU store data.
- `o_CPU_Read_Data`  out  BusWidth  memory read data to CPU.
- `o_CPU_Stall`  out  1  CPU must hold its PC and request this cycle.
- `i_EXT_Valid`  in  1  external request pending.
- `o_EXT_Ready`  out  1  external request accepted this cycle.
- `i_EXT_Write`  in  1  external write.
- `i_EXT_Address`  in  BusWidth  external address.
- `i_EXT_Write_Data`  in  BusWidth  external write data.
- `o_EXT_Read_Data`  out  BusWidth  registered external read data.
- `o_EXT_Read_Valid`  out  1  one-cycle pulse, `o_EXT_Read_Data` valid.
- `o_Mem_Address`  out  BusWidth  to data memory.
- `o_Mem_Write`  out  1  to data memory.
- `o_Mem_Write_Data`  out  BusWidth  to data memory.
- `i_Mem_Read_Data`  in  BusWidth  combinational read from data memory.

## Operation

- `starve` = (`wait_cnt` == `MaxWait`).
- `ext_grant` = `i_EXT_Valid` && (!`i_CPU_Req` || `starve`).
- `o_EXT_Ready` = `ext_grant`. A transfer occurs on `i_EXT_Valid` && `o_EXT_Ready`.
- `o_CPU_Stall` = `i_CPU_Req` && `ext_grant`.
- Memory mux:
  - When `ext_grant`, memory address/write/data come from the EXT port.
  - Otherwise they come from the CPU port.
  - `o_Mem_Write` = `i_CPU_Write` && `i_CPU_Req` when the CPU owns the port.
  - No memory write when neither side is active.
- `o_CPU_Read_Data` = `i_Mem_Read_Data`, always combinational.
- `wait_cnt` (state, width `$clog2(MaxWait+1)`) is updated in priority order:
  1. Reset → 0.
  2. EXT transfer → 0.
  3. !`i_EXT_Valid` → 0.
  4. Valid and refused → increment, saturating at `MaxWait`.
- Effective states:
  - CPU_OWN (`wait_cnt` < `MaxWait`).
  - EXT_FORCED (`wait_cnt` == `MaxWait`). Lasts exactly one cycle, because the forced grant transfers and clears the counter.
- EXT read transfer: `i_Mem_Read_Data` is captured into `o_EXT_Read_Data` at the edge. `o_EXT_Read_Valid` = 1 for the following cycle only.
- Boundary conditions:
  - Simultaneous CPU and EXT requests with `wait_cnt` < `MaxWait`: CPU wins, EXT is refused and the counter increments.
  - EXT drops `i_EXT_Valid` while waiting: counter clears.
  - Back-to-back EXT reads: `o_EXT_Read_Valid` stays high on consecutive cycles, each with fresh data.
  - EXT write transfer: no read pulse.

## Timing

- CPU path is zero latency: address to memory and read data back within the same cycle.
- EXT write commits at the rising edge ending the transfer cycle.
- EXT read data is visible one cycle after the transfer.
- Worst-case EXT wait under continuous CPU traffic: `MaxWait` cycles, granted on cycle `MaxWait`+1.
- CPU stall bound: at most one stalled cycle per `MaxWait`+1 cycles.
- Reset values:
  - `wait_cnt` = 0.
  - `o_EXT_Read_Valid` = 0.
  - `o_EXT_Read_Data` = 0.
  - All combinational outputs follow their inputs.
- Reset during the cycle after a read transfer suppresses the pending read pulse.

## Configuration

- `ARM_DMEM_ARB_STARVE_EN`
  - Defined: starvation counter active as described.
  - Undefined: `starve` is tied to 0 and `wait_cnt` is not implemented. This gives strict CPU priority: EXT is granted only on cycles with `i_CPU_Req` = 0, and `o_CPU_Stall` is constant 0.

## Structure

- Package `arm_dmem_arb_pkg`:
  - Grant-owner enum `{GRANT_CPU, GRANT_EXT}`.
  - `MAXWAIT_LIMIT` = 255.
  - Helper function for counter width.
- Sub-module `arm_starve_counter`: saturating, clearable counter with a `MaxWait` compare output. Instantiated only under `ARM_DMEM_ARB_STARVE_EN`.

## Test plan

- **CPU only.** `i_CPU_Req`=1, write 0xDEADBEEF to 0x40, then read 0x40 → same-cycle read data 0xDEADBEEF; `o_CPU_Stall`=0 throughout.
- **EXT read while CPU idle.**
  - Setup: memory[0x80] = 0x12345678.
  - Stimulus: EXT read of 0x80 while `i_CPU_Req`=0.
  - Response: `o_EXT_Ready`=1 the same cycle; next cycle `o_EXT_Read_Valid`=1 and `o_EXT_Read_Data`=0x12345678.
- **Starvation (`MaxWait`=4, macro on).**
  - Stimulus: `i_CPU_Req` and `i_EXT_Valid` held high continuously.
  - Response: `o_EXT_Ready` is 0 for cycles 1–4 and 1 on cycle 5, with `o_CPU_Stall`=1 on cycle 5 only; the pattern repeats every 5 cycles.
- **Macro off, same stimulus as the starvation test.** `o_EXT_Ready` never asserts and `o_CPU_Stall` stays 0. Dropping `i_CPU_Req` grants EXT in that same cycle.
- **EXT withdrawal.** EXT valid for 3 refused cycles, then low for 1 cycle, then high → counter restarts, and a grant needs 4 further refused cycles.
- **Reset mid-read.** `i_RESET`=1 in the cycle after an EXT read transfer → `o_EXT_Read_Valid`=0 and `o_EXT_Read_Data`=0 next cycle; `wait_cnt`=0.

Source files
------------

// File: rtl/arm_dmem_arb_pkg.sv
// Shared types and helpers for the CPU/external data-memory arbiter.
package arm_dmem_arb_pkg;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_EXT = 1'b1
    } grant_e;

    localparam int unsigned MAXWAIT_LIMIT = 255;

    function automatic int unsigned cnt_width(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/arm_starve_counter.sv
// Saturating, clearable wait counter; flags when the count reaches MaxWait.
module arm_starve_counter
    import arm_dmem_arb_pkg::*;
#(
    parameter int unsigned MaxWait = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam int unsigned CntWidth = cnt_width(MaxWait);
    localparam logic [CntWidth-1:0] MaxVal = CntWidth'(MaxWait);

    logic [CntWidth-1:0] cnt_q;

    assign at_max_o = (cnt_q == MaxVal);

    // Clear has priority over increment; increment holds at MaxVal.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i && !at_max_o) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

endmodule

// File: rtl/arm_dmem_arbiter.sv
// Shares the data memory between the CPU (favoured, combinational) and an external port.
// ARM_DMEM_ARB_STARVE_EN enables the starvation counter; without it the CPU has strict priority.
module arm_dmem_arbiter
    import arm_dmem_arb_pkg::*;
#(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned MaxWait  = 4
) (
    input  logic                i_CLK,
    input  logic                i_RESET,
    input  logic                i_CPU_Req,
    input  logic                i_CPU_Write,
    input  logic [BusWidth-1:0] i_CPU_Address,
    input  logic [BusWidth-1:0] i_CPU_Write_Data,
    output logic [BusWidth-1:0] o_CPU_Read_Data,
    output logic                o_CPU_Stall,
    input  logic                i_EXT_Valid,
    output logic                o_EXT_Ready,
    input  logic                i_EXT_Write,
    input  logic [BusWidth-1:0] i_EXT_Address,
    input  logic [BusWidth-1:0] i_EXT_Write_Data,
    output logic [BusWidth-1:0] o_EXT_Read_Data,
    output logic                o_EXT_Read_Valid,
    output logic [BusWidth-1:0] o_Mem_Address,
    output logic                o_Mem_Write,
    output logic [BusWidth-1:0] o_Mem_Write_Data,
    input  logic [BusWidth-1:0] i_Mem_Read_Data
);

    if (MaxWait < 1 || MaxWait > MAXWAIT_LIMIT) begin : g_bad_maxwait
        $error("arm_dmem_arbiter: MaxWait out of range 1..255");
    end

    logic   starve;
    logic   ext_grant;
    grant_e owner;

`ifdef ARM_DMEM_ARB_STARVE_EN
    // A granted request always transfers, so the forced state lasts one cycle.
    arm_starve_counter #(
        .MaxWait (MaxWait)
    ) u_starve_counter (
        .clk_i    (i_CLK),
        .rst_i    (i_RESET),
        .clear_i  (!i_EXT_Valid || ext_grant),
        .inc_i    (i_EXT_Valid && !ext_grant),
        .at_max_o (starve)
    );
`else
    assign starve = 1'b0;
`endif

    assign ext_grant   = i_EXT_Valid && (!i_CPU_Req || starve);
    assign owner       = ext_grant ? GRANT_EXT : GRANT_CPU;
    assign o_EXT_Ready = ext_grant;
    assign o_CPU_Stall = i_CPU_Req && ext_grant;

    assign o_CPU_Read_Data = i_Mem_Read_Data;

    always_comb begin
        o_Mem_Address    = i_CPU_Address;
        o_Mem_Write      = i_CPU_Write && i_CPU_Req;
        o_Mem_Write_Data = i_CPU_Write_Data;
        unique case (owner)
            GRANT_EXT: begin
                o_Mem_Address    = i_EXT_Address;
                o_Mem_Write      = i_EXT_Write;
                o_Mem_Write_Data = i_EXT_Write_Data;
            end
            GRANT_CPU: ;
            default: ;
        endcase
    end

    logic                ext_rd_valid_q;
    logic [BusWidth-1:0] ext_rd_data_q;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            ext_rd_valid_q <= 1'b0;
            ext_rd_data_q  <= '0;
        end else begin
            ext_rd_valid_q <= ext_grant && !i_EXT_Write;
            if (ext_grant && !i_EXT_Write) begin
                ext_rd_data_q <= i_Mem_Read_Data;
            end
        end
    end

    assign o_EXT_Read_Valid = ext_rd_valid_q;
    assign o_EXT_Read_Data  = ext_rd_data_q;

endmodule

// File: tb/tb_arm_dmem_arbiter.sv
// Directed self-checking bench for arm_dmem_arbiter with a small word-addressed memory model.
module tb_arm_dmem_arbiter;

    localparam int unsigned BusWidth = 32;
    localparam int unsigned MaxWait  = 4;

`ifdef ARM_DMEM_ARB_STARVE_EN
    localparam bit StarveOn = 1'b1;
`else
    localparam bit StarveOn = 1'b0;
`endif

    logic                i_CLK = 1'b0;
    logic                i_RESET;
    logic                i_CPU_Req;
    logic                i_CPU_Write;
    logic [BusWidth-1:0] i_CPU_Address;
    logic [BusWidth-1:0] i_CPU_Write_Data;
    logic [BusWidth-1:0] o_CPU_Read_Data;
    logic                o_CPU_Stall;
    logic                i_EXT_Valid;
    logic                o_EXT_Ready;
    logic                i_EXT_Write;
    logic [BusWidth-1:0] i_EXT_Address;
    logic [BusWidth-1:0] i_EXT_Write_Data;
    logic [BusWidth-1:0] o_EXT_Read_Data;
    logic                o_EXT_Read_Valid;
    logic [BusWidth-1:0] o_Mem_Address;
    logic                o_Mem_Write;
    logic [BusWidth-1:0] o_Mem_Write_Data;
    logic [BusWidth-1:0] i_Mem_Read_Data;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_CLK = ~i_CLK;

    assign i_Mem_Read_Data = mem[o_Mem_Address[9:2]];

    always @(posedge i_CLK) begin
        if (o_Mem_Write) mem[o_Mem_Address[9:2]] <= o_Mem_Write_Data;
    end

    arm_dmem_arbiter #(
        .BusWidth (BusWidth),
        .MaxWait  (MaxWait)
    ) dut (
        .i_CLK            (i_CLK),
        .i_RESET          (i_RESET),
        .i_CPU_Req        (i_CPU_Req),
        .i_CPU_Write      (i_CPU_Write),
        .i_CPU_Address    (i_CPU_Address),
        .i_CPU_Write_Data (i_CPU_Write_Data),
        .o_CPU_Read_Data  (o_CPU_Read_Data),
        .o_CPU_Stall      (o_CPU_Stall),
        .i_EXT_Valid      (i_EXT_Valid),
        .o_EXT_Ready      (o_EXT_Ready),
        .i_EXT_Write      (i_EXT_Write),
        .i_EXT_Address    (i_EXT_Address),
        .i_EXT_Write_Data (i_EXT_Write_Data),
        .o_EXT_Read_Data  (o_EXT_Read_Data),
        .o_EXT_Read_Valid (o_EXT_Read_Valid),
        .o_Mem_Address    (o_Mem_Address),
        .o_Mem_Write      (o_Mem_Write),
        .o_Mem_Write_Data (o_Mem_Write_Data),
        .i_Mem_Read_Data  (i_Mem_Read_Data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
        i_CPU_Req        = req;
        i_CPU_Write      = wr;
        i_CPU_Address    = addr;
        i_CPU_Write_Data = data;
    endtask

    task automatic drive_ext(input logic vld, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data);
        i_EXT_Valid      = vld;
        i_EXT_Write      = wr;
        i_EXT_Address    = addr;
        i_EXT_Write_Data = data;
    endtask

    logic        exp_rdy;
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];

    initial begin
        wr_addr = '{32'h80, 32'h84, 32'h88};
        wr_data = '{32'h1234_5678, 32'hA5A5_0001, 32'hA5A5_0002};

        // Reset; CPU_Write high but no request, so no memory write.
        i_RESET = 1'b1;
        drive_cpu(1'b0, 1'b1, 32'h40, 32'h0);
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        next_cycle();
        i_RESET = 1'b0;
        #3;
        chk("rst_rd_valid", {31'b0, o_EXT_Read_Valid}, 32'h0);
        chk("rst_rd_data", o_EXT_Read_Data, 32'h0);
        chk("rst_ready", {31'b0, o_EXT_Ready}, 32'h0);
        chk("rst_stall", {31'b0, o_CPU_Stall}, 32'h0);
        chk("idle_no_write", {31'b0, o_Mem_Write}, 32'h0);
        next_cycle();

        // Preload memory through EXT writes while CPU is idle.
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive_ext(1'b1, 1'b1, wr_addr[i], wr_data[i]);
            #3;
            chk($sformatf("extwr%0d_ready", i), {31'b0, o_EXT_Ready}, 32'h1);
            chk($sformatf("extwr%0d_memwr", i), {31'b0, o_Mem_Write}, 32'h1);
            chk($sformatf("extwr%0d_addr", i), o_Mem_Address, wr_addr[i]);
            chk($sformatf("extwr%0d_wdata", i), o_Mem_Write_Data, wr_data[i]);
            next_cycle();
        end
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("extwr_no_rd_pulse", {31'b0, o_EXT_Read_Valid}, 32'h0);
        next_cycle();

        // CPU only: write then read back in the same cycle.
        drive_cpu(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF);
        #3;
        chk("cpuwr_memwr", {31'b0, o_Mem_Write}, 32'h1);
        chk("cpuwr_addr", o_Mem_Address, 32'h40);
        chk("cpuwr_wdata", o_Mem_Write_Data, 32'hDEAD_BEEF);
        chk("cpuwr_stall", {31'b0, o_CPU_Stall}, 32'h0);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        #3;
        chk("cpurd_data", o_CPU_Read_Data, 32'hDEAD_BEEF);
        chk("cpurd_memwr", {31'b0, o_Mem_Write}, 32'h0);
        chk("cpurd_stall", {31'b0, o_CPU_Stall}, 32'h0);
        next_cycle();
        drive_cpu(1'b1, 1'b0, 32'h80, 32'h0);
        #3;
        chk("cpurd_extwritten", o_CPU_Read_Data, 32'h1234_5678);
        next_cycle();

        // EXT read while CPU idle.
        drive_cpu(1'b0, 1'b0, 32'h40, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h80, 32'h0);
        #3;
        chk("extrd_ready", {31'b0, o_EXT_Ready}, 32'h1);
        chk("extrd_addr", o_Mem_Address, 32'h80);
        chk("extrd_memwr", {31'b0, o_Mem_Write}, 32'h0);
        chk("extrd_stall", {31'b0, o_CPU_Stall}, 32'h0);
        next_cycle();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("extrd_valid", {31'b0, o_EXT_Read_Valid}, 32'h1);
        chk("extrd_data", o_EXT_Read_Data, 32'h1234_5678);
        next_cycle();
        #3;
        chk("extrd_pulse_end", {31'b0, o_EXT_Read_Valid}, 32'h0);

        // Back-to-back EXT reads.
        drive_ext(1'b1, 1'b0, 32'h84, 32'h0);
        next_cycle();
        drive_ext(1'b1, 1'b0, 32'h88, 32'h0);
        #3;
        chk("b2b_valid0", {31'b0, o_EXT_Read_Valid}, 32'h1);
        chk("b2b_data0", o_EXT_Read_Data, 32'hA5A5_0001);
        next_cycle();
        drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("b2b_valid1", {31'b0, o_EXT_Read_Valid}, 32'h1);
        chk("b2b_data1", o_EXT_Read_Data, 32'hA5A5_0002);
        next_cycle();
        #3;
        chk("b2b_pulse_end", {31'b0, o_EXT_Read_Valid}, 32'h0);

        // Continuous contention: forced grant every MaxWait+1 cycles when enabled.
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h80, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            #3;
            exp_rdy = StarveOn && (k % 5 == 0);
            chk($sformatf("starve_ready_c%0d", k), {31'b0, o_EXT_Ready}, {31'b0, exp_rdy});
            chk($sformatf("starve_stall_c%0d", k), {31'b0, o_CPU_Stall}, {31'b0, exp_rdy});
            chk($sformatf("starve_addr_c%0d", k), o_Mem_Address,
                exp_rdy ? 32'h80 : 32'h40);
            next_cycle();
        end
        drive_cpu(1'b0, 1'b0, 32'h40, 32'h0);
        #3;
        chk("cpu_drop_ready", {31'b0, o_EXT_Ready}, 32'h1);
        chk("cpu_drop_stall", {31'b0, o_CPU_Stall}, 32'h0);
        next_cycle();

        // Withdrawal: 3 refused, 1 idle, then a fresh 4 refused before a grant.
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            #3;
            chk($sformatf("wd_pre_ready_c%0d", k), {31'b0, o_EXT_Ready}, 32'h0);
            next_cycle();
        end
        i_EXT_Valid = 1'b0;
        #3;
        chk("wd_gap_ready", {31'b0, o_EXT_Ready}, 32'h0);
        next_cycle();
        i_EXT_Valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #3;
            exp_rdy = StarveOn && (k == 5);
            chk($sformatf("wd_post_ready_c%0d", k), {31'b0, o_EXT_Ready}, {31'b0, exp_rdy});
            next_cycle();
        end

        // Reset in the cycle after a read transfer, with a refused request pending.
        drive_cpu(1'b0, 1'b0, 32'h40, 32'h0);
        drive_ext(1'b1, 1'b0, 32'h80, 32'h0);
        #3;
        chk("rstrd_ready", {31'b0, o_EXT_Ready}, 32'h1);
        next_cycle();
        i_RESET = 1'b1;
        drive_cpu(1'b1, 1'b0, 32'h40, 32'h0);
        next_cycle();
        i_RESET = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            #3;
            if (k == 1) begin
                chk("rstrd_valid", {31'b0, o_EXT_Read_Valid}, 32'h0);
                chk("rstrd_data", o_EXT_Read_Data, 32'h0);
            end
            exp_rdy = StarveOn && (k == 5);
            chk($sformatf("rstcnt_ready_c%0d", k), {31'b0, o_EXT_Ready}, {31'b0, exp_rdy});
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
